// File: rtl/sprite_palette_bank_if.sv
// Lookup, write and flash-control signals of the sprite palette bank.
// The renderer side (master) drives requests; the palette bank (slave) answers.
interface sprite_palette_bank_if #(
    parameter int INDEX_W = 4,
    parameter int NUM_PAL = 4,
    parameter int COLOR_W = 4
);
    localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;

    logic                   rd_en;
    logic [PAL_W-1:0]       pal_sel;
    logic [INDEX_W-1:0]     index;
    logic                   wr_en;
    logic [PAL_W-1:0]       wr_pal;
    logic [INDEX_W-1:0]     wr_index;
    logic [3*COLOR_W-1:0]   wr_data;
    logic                   frame_tick;
    logic                   flash_en;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   transparent;
    logic                   rd_valid;
    logic                   flash_phase;

    modport master (
        output rd_en, pal_sel, index, wr_en, wr_pal, wr_index, wr_data,
               frame_tick, flash_en,
        input  red, green, blue, transparent, rd_valid, flash_phase
    );

    modport slave (
        input  rd_en, pal_sel, index, wr_en, wr_pal, wr_index, wr_data,
               frame_tick, flash_en,
        output red, green, blue, transparent, rd_valid, flash_phase
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-palette colour lookup with transparency flag and
// frame-driven flash between a palette and its LSB-flipped partner.
// One cycle of lookup latency; same-cycle writes bypass into the lookup.
module sprite_palette_bank #(
    parameter int INDEX_W      = 4,
    parameter int NUM_PAL      = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_palette_bank_if.slave  bus
);
    localparam int PAL_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int ADDR_W = PAL_W + INDEX_W;
    localparam int DEPTH  = NUM_PAL << INDEX_W;
    localparam int DATA_W = 3 * COLOR_W;
    localparam int CNT_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    // Palette storage is plain registers: it must clear on reset and is
    // read combinationally, so it cannot map onto block RAM.
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic [DATA_W-1:0] color_reg;
    logic              transp_reg;
    logic              rd_valid_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;
    logic              flash_phase_reg;

    logic [PAL_W-1:0]  flip_mask;
    logic [PAL_W-1:0]  eff_pal;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              bypass;
    logic [DATA_W-1:0] rd_data;

    // Flash only ever flips the palette LSB, pairing palettes 0/1, 2/3, ...
    assign flip_mask = PAL_W'(flash_phase_reg & bus.flash_en);
    assign eff_pal   = bus.pal_sel ^ flip_mask;
    assign rd_addr   = {eff_pal, bus.index};
    assign wr_addr   = {bus.wr_pal, bus.wr_index};
    // Bypass compares against the flashed palette, i.e. the entry really read.
    assign bypass    = bus.wr_en && (wr_addr == rd_addr);
    assign rd_data   = bypass ? bus.wr_data : mem_reg[rd_addr];

    // Palette entry writes; whole array clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.wr_en) begin
            mem_reg[wr_addr] <= bus.wr_data;
        end
    end

    // Lookup output stage: colour and transparency hold while rd_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_reg    <= '0;
            transp_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                color_reg  <= rd_data;
                transp_reg <= (bus.index == INDEX_W'(TRANSP_IDX));
            end
        end
    end

    // Frame counter and flash phase; disabling flash restarts at phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg   <= '0;
            flash_phase_reg <= 1'b0;
        end else if (!bus.flash_en) begin
            frame_cnt_reg   <= '0;
            flash_phase_reg <= 1'b0;
        end else if (bus.frame_tick) begin
            if (frame_cnt_reg == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_reg   <= '0;
                flash_phase_reg <= ~flash_phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.red         = color_reg[DATA_W-1 -: COLOR_W];
    assign bus.green       = color_reg[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue        = color_reg[COLOR_W-1:0];
    assign bus.transparent = transp_reg;
    assign bus.rd_valid    = rd_valid_reg;
    assign bus.flash_phase = flash_phase_reg;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank (FLASH_FRAMES = 2).
// Directed table, hand-written flash/hold/reset sequences, then random
// traffic against a palette/tick-count reference model.
module tb_sprite_palette_bank;
    localparam int FF = 2;

    logic clk;
    logic reset;

    sprite_palette_bank_if #(.INDEX_W(4), .NUM_PAL(4), .COLOR_W(4)) bus ();

    sprite_palette_bank #(
        .INDEX_W(4), .NUM_PAL(4), .COLOR_W(4), .TRANSP_IDX(0), .FLASH_FRAMES(FF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: palette contents, ticks counted since flash enabled,
    // and the last looked-up values.
    logic [11:0] m_mem [4][16];
    int          m_ticks;
    logic [11:0] e_rgb;
    logic        e_tr;
    logic        e_valid;

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_pal;
        logic [3:0]  wr_index;
        logic [11:0] wr_data;
        logic        rd_en;
        logic [1:0]  pal_sel;
        logic [3:0]  index;
        logic [11:0] exp_rgb;
        logic        exp_tr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_phase();
        return ((m_ticks / FF) % 2) == 1;
    endfunction

    function automatic logic [11:0] dut_rgb();
        return {bus.red, bus.green, bus.blue};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                m_mem[p][i] = 12'h000;
        m_ticks = 0;
        e_rgb   = 12'h000;
        e_tr    = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic set_inputs(input logic we, input logic [1:0] wp, input logic [3:0] wi,
                              input logic [11:0] wd, input logic re, input logic [1:0] ps,
                              input logic [3:0] ix);
        bus.wr_en    = we;
        bus.wr_pal   = wp;
        bus.wr_index = wi;
        bus.wr_data  = wd;
        bus.rd_en    = re;
        bus.pal_sel  = ps;
        bus.index    = ix;
    endtask

    // One clock: predict from the model, advance it, then compare after the edge.
    task automatic cycle();
        int eff;
        if (bus.rd_en) begin
            eff = int'(bus.pal_sel) ^ ((m_phase() && bus.flash_en) ? 1 : 0);
            if (bus.wr_en && int'(bus.wr_pal) == eff && bus.wr_index == bus.index)
                e_rgb = bus.wr_data;
            else
                e_rgb = m_mem[eff][bus.index];
            e_tr    = (bus.index == 4'd0);
            e_valid = 1'b1;
        end else begin
            e_valid = 1'b0;
        end
        if (bus.wr_en) m_mem[bus.wr_pal][bus.wr_index] = bus.wr_data;
        if (!bus.flash_en) m_ticks = 0;
        else if (bus.frame_tick) m_ticks++;
        @(posedge clk);
        #1;
        check("rd_valid", 32'(bus.rd_valid), 32'(e_valid));
        check("rgb", 32'(dut_rgb()), 32'(e_rgb));
        check("transparent", 32'(bus.transparent), 32'(e_tr));
        check("flash_phase", 32'(bus.flash_phase), 32'(m_phase()));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, 32'(dut_rgb()), 32'h0);
        check({tag, "_transparent"}, 32'(bus.transparent), 32'h0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
        check({tag, "_flash_phase"}, 32'(bus.flash_phase), 32'h0);
    endtask

    initial begin
        // Directed vectors, starting from a freshly reset bank with flash off.
        vecs[0] = '{1'b1, 2'd2, 4'd5, 12'hF80, 1'b0, 2'd0, 4'd0, 12'h000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd2, 4'd5, 12'hF80, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 2'd0, 4'd3, 12'h123, 1'b0, 2'd0, 4'd0, 12'hF80, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'd1, 4'd3, 12'h0A5, 1'b1, 2'd1, 4'd3, 12'h0A5, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd0, 4'd3, 12'h123, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd1, 4'd3, 12'h0A5, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 2'd0, 4'd0, 12'h456, 1'b1, 2'd3, 4'd1, 12'h000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd0, 4'd0, 12'h456, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd0, 4'd1, 12'h000, 1'b0, 1'b1};

        reset = 1'b1;
        set_inputs(1'b0, 2'd0, 4'd0, 12'h000, 1'b0, 2'd0, 4'd0);
        bus.frame_tick = 1'b0;
        bus.flash_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Table-driven write / read / bypass / transparency.
        for (int v = 0; v < 9; v++) begin
            set_inputs(vecs[v].wr_en, vecs[v].wr_pal, vecs[v].wr_index, vecs[v].wr_data,
                       vecs[v].rd_en, vecs[v].pal_sel, vecs[v].index);
            cycle();
            check($sformatf("vec%0d_rgb", v), 32'(dut_rgb()), 32'(vecs[v].exp_rgb));
            check($sformatf("vec%0d_transparent", v), 32'(bus.transparent), 32'(vecs[v].exp_tr));
            check($sformatf("vec%0d_rd_valid", v), 32'(bus.rd_valid), 32'(vecs[v].exp_valid));
            $display("[TB] vec %0d: rd=%0b pal=%0d idx=%0d -> rgb=%03h tr=%0b valid=%0b",
                     v, vecs[v].rd_en, vecs[v].pal_sel, vecs[v].index,
                     dut_rgb(), bus.transparent, bus.rd_valid);
        end

        // Flash: load pal2/pal3 idx7, then tick frames while reading pal_sel=2.
        set_inputs(1'b1, 2'd2, 4'd7, 12'h111, 1'b0, 2'd0, 4'd0);
        cycle();
        set_inputs(1'b1, 2'd3, 4'd7, 12'h222, 1'b0, 2'd0, 4'd0);
        cycle();
        set_inputs(1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd2, 4'd7);
        bus.flash_en = 1'b1;
        cycle();
        check("flash_start_rgb", 32'(dut_rgb()), 32'h111);
        bus.frame_tick = 1'b1;
        cycle();
        check("flash_tick1_phase", 32'(bus.flash_phase), 32'h0);
        cycle();
        check("flash_tick2_phase", 32'(bus.flash_phase), 32'h1);
        bus.frame_tick = 1'b0;
        cycle();
        check("flash_phase1_rgb", 32'(dut_rgb()), 32'h222);
        $display("[TB] flash: phase=%0b rgb=%03h", bus.flash_phase, dut_rgb());
        bus.frame_tick = 1'b1;
        cycle();
        cycle();
        bus.frame_tick = 1'b0;
        cycle();
        check("flash_phase0_rgb", 32'(dut_rgb()), 32'h111);
        bus.frame_tick = 1'b1;
        cycle();
        cycle();
        bus.frame_tick = 1'b0;
        check("flash_before_off", 32'(bus.flash_phase), 32'h1);
        bus.flash_en = 1'b0;
        cycle();
        check("flash_off_phase", 32'(bus.flash_phase), 32'h0);
        $display("[TB] flash off: phase=%0b", bus.flash_phase);

        // Hold: a valid read followed by five idle cycles.
        set_inputs(1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd2, 4'd5);
        cycle();
        check("hold_read_rgb", 32'(dut_rgb()), 32'hF80);
        bus.rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.index   = 4'(k + 1);
            bus.pal_sel = 2'(k);
            cycle();
            check($sformatf("hold%0d_valid", k), 32'(bus.rd_valid), 32'h0);
            check($sformatf("hold%0d_rgb", k), 32'(dut_rgb()), 32'hF80);
        end
        $display("[TB] hold: rgb=%03h valid=%0b", dut_rgb(), bus.rd_valid);

        // Reset mid-stream: outputs must clear without a clock edge.
        set_inputs(1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd1, 4'd3);
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        $display("[TB] async reset: rgb=%03h valid=%0b", dut_rgb(), bus.rd_valid);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_inputs(1'b0, 2'd0, 4'd0, 12'h000, 1'b1, 2'd2, 4'd5);
        cycle();
        check("post_reset_rgb", 32'(dut_rgb()), 32'h000);
        check("post_reset_valid", 32'(bus.rd_valid), 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            set_inputs(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 12'($urandom),
                       1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom_range(0, 3)));
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) bus.flash_en = ~bus.flash_en;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
